event_pulse_stretcher: RTL
==========================

// Module: event_pulse_stretcher
// PURPOSE
//  Output-side counterpart of the key debounce/edge stage: turns 1-cycle game event pulses
//  (line clear, piece lock, game over) into human-visible level pulses.
//  Typical loads are an LED or buzzer enable.
//  Each accepted event yields one distinct ON window followed by a mandatory OFF gap.
//  Events arriving while busy are queued in a saturating counter, so bursts replay as
//  separate blinks.
// PARAMETERS
//  ON_CYCLES   5_000_000  cycles level_out is high per event (>=1; 50 ms @ 100 MHz)
//  GAP_CYCLES  5_000_000  cycles level_out is forced low after each ON window (>=1)
//  PEND_W      4          width of pending-event counter; max queued = 2**PEND_W-1
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  pulse_in   in   1       event strobe, 1 clk wide, synchronous to clk
//  clear      in   1       synchronous flush: abort output, drop queue, clear overflow
//  level_out  out  1       stretched drive level (registered)
//  busy       out  1       high when state != IDLE
//  pend_cnt   out  PEND_W  events queued, excluding the one being displayed
//  overflow   out  1       sticky: an event was dropped because pend_cnt was saturated
// BEHAVIOUR
//  Reset is asynchronous. All outputs go to 0, state goes to IDLE, and the timer goes to 0.
//  FSM states and transitions:
//  - IDLE: level_out=0.
//    pulse_in=1 -> ON, timer<=ON_CYCLES-1.
//    pend_cnt is always 0 in IDLE.
//  - ON: level_out=1; timer decrements by 1 per cycle.
//    timer==0 -> GAP, timer<=GAP_CYCLES-1.
//  - GAP: level_out=0; timer decrements by 1 per cycle.
//    When timer==0:
//    - if pend_cnt>0 or pulse_in -> ON, timer<=ON_CYCLES-1.
//    - else -> IDLE.
//  Latency: pulse_in sampled in IDLE at edge k makes level_out=1 from edge k+1.
//  Widths: level_out is high for exactly ON_CYCLES cycles, then low for at least GAP_CYCLES cycles.
//  Queue rules:
//  - pulse_in in ON or GAP (not consumed) increments pend_cnt.
//  - GAP->ON with pend_cnt>0 decrements pend_cnt.
//  - If both happen in one cycle, pend_cnt is unchanged.
//  - A GAP->ON transition triggered only by the same-cycle pulse_in leaves pend_cnt unchanged.
//  Saturation: a pulse_in when pend_cnt==2**PEND_W-1 and no same-cycle consume is dropped,
//  sets overflow<=1 and leaves pend_cnt unchanged. overflow stays set until clear or reset.
//  clear has priority over pulse_in. Next cycle: IDLE, level_out=0, pend_cnt=0, overflow=0, timer=0.
//  Reset or clear mid-ON truncates the window; no residual blink is produced.
//  Timer width is $clog2(max(ON_CYCLES,GAP_CYCLES)+1). Counters never wrap.
// STRUCTURE
//  Shared package/header: IDLE/ON/GAP state encoding localparams; a common clk-frequency
//  constant used to derive ON_CYCLES/GAP_CYCLES in ms.
//  One natural sub-module: sat_updown_counter (PEND_W, inc, dec, cnt, sat).
//  - Same-cycle inc&dec holds.
//  - Saturates at max on inc; clamps at 0 on dec.
//  The FSM and down-timer stay inline.
// TESTING  (ON_CYCLES=4, GAP_CYCLES=2, PEND_W=2)
//  1. Single pulse in IDLE at edge 0 -> level_out=1 at edges 1..4, 0 at 5..6;
//     busy drops at edge 7; pend_cnt stays 0.
//  2. Pulses at edges 0,1,2 -> three 4-cycle highs separated by 2-cycle lows;
//     pend_cnt peaks at 2, then reads 0 by the third ON.
//  3. Five pulses during the first ON window -> pend_cnt saturates at 3, overflow=1;
//     exactly 4 blinks total; overflow stays 1 afterwards.
//  4. Pulse on the last GAP cycle with pend_cnt=0 -> ON on the next edge, no IDLE cycle;
//     pend_cnt stays 0.
//  5. clear together with pulse_in mid-ON and pend_cnt=2 -> next edge: level_out=0,
//     busy=0, pend_cnt=0, overflow=0; no later blinks.
//  6. rst_n low asynchronously mid-GAP (between edges) -> all outputs 0 immediately;
//     after release, a pulse behaves as in test 1.

Source files
------------

// File: rtl/event_pulse_stretcher_pkg.sv
// Shared constants for the event pulse stretcher.
// State encoding and ms-to-cycle conversion.
package event_pulse_stretcher_pkg;

  localparam int CLK_HZ = 100_000_000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter for queued events.
// Simultaneous inc and dec hold the value.
module sat_updown_counter #(
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              sat
);

  localparam logic [PEND_W-1:0] MAX = '1;

  assign sat = (cnt == MAX);

  // count up to MAX, down to zero, never wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/event_pulse_stretcher.sv
// Stretches 1-cycle event strobes into ON windows
// separated by OFF gaps; bursts are queued.
module event_pulse_stretcher
  import event_pulse_stretcher_pkg::*;
#(
  parameter int ON_CYCLES  = ms_to_cycles(50),
  parameter int GAP_CYCLES = ms_to_cycles(50),
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int TMAX =
    (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic          on_s;
  logic          gap_s;
  logic          expire;
  logic          pend_nz;
  logic          inc;
  logic          dec;
  logic          sat;

  assign on_s    = (state == ST_ON);
  assign gap_s   = (state == ST_GAP);
  assign expire  = (timer == '0);
  assign pend_nz = (pend_cnt != '0);
  assign busy    = (state != ST_IDLE);

  // a pulse that itself restarts ON from an empty queue is consumed
  assign inc = pulse_in &&
               (on_s || (gap_s && !(expire && !pend_nz)));
  assign dec = gap_s && expire && pend_nz;

  // next state and timer
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    unique case (1'b1)
      on_s: begin
        if (expire) begin
          state_nx = ST_GAP;
          timer_nx = GAP_LOAD;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      gap_s: begin
        if (expire) begin
          if (pend_nz || pulse_in) begin
            state_nx = ST_ON;
            timer_nx = ON_LOAD;
          end else begin
            state_nx = ST_IDLE;
            timer_nx = '0;
          end
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      default: begin
        if (pulse_in) begin
          state_nx = ST_ON;
          timer_nx = ON_LOAD;
        end
      end
    endcase
  end

  // state, timer and registered drive level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      level_out <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      timer     <= '0;
      level_out <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      level_out <= (state_nx == ST_ON);
    end
  end

  // sticky flag for events lost to a full queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (inc && !dec && sat) begin
      overflow <= 1'b1;
    end
  end

  sat_updown_counter #(
    .PEND_W(PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (inc),
    .dec   (dec),
    .cnt   (pend_cnt),
    .sat   (sat)
  );

endmodule
